// File: rtl/vec_data_mem_resp.sv
// vec_data_mem_resp: single-outstanding 16-lane unit-stride load/store responder over a 64-word memory.
// Contents self-initialise to mem[i]=i+1 after every reset; a reset drops any in-flight request.
module vec_data_mem_resp #(
   parameter int DEPTH  = 64,
   parameter int LANES  = 16,
   parameter int VSEW   = 32,
   parameter int RD_LAT = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [$clog2(DEPTH)-1:0]      req_addr,
   input  logic [LANES-1:0]              req_mask,
   input  logic [LANES*VSEW-1:0]         req_wdata,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic                          resp_is_store,
   output logic [LANES*VSEW-1:0]         resp_rdata,
   output logic                          busy_init
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {INIT, IDLE, RD, WR, RESP} state_t;
   state_t state, state_nx;
   logic [AW-1:0] ptr, addr_q;
   logic [LANES-1:0] mask_q;
   logic [LANES*VSEW-1:0] wdata_q, rd_data;
   logic [2:0] cnt;
   logic [VSEW-1:0] mem [DEPTH];
   assign req_ready = state == IDLE;
   assign busy_init = state == INIT;
   always_comb begin
      state_nx = state;
      case (state)
         INIT:    state_nx = ptr == AW'(DEPTH-1) ? IDLE : INIT;
         IDLE:    state_nx = req_valid ? (req_we ? WR : RD) : IDLE;
         RD:      state_nx = cnt == 3'd0 ? RESP : RD;
         WR:      state_nx = RESP;
         RESP:    state_nx = resp_ready ? IDLE : RESP;
         default: state_nx = INIT;
      endcase
   end
   // Lane addresses wrap naturally through AW-bit addition.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < LANES; k++)
         rd_data[k*VSEW +: VSEW] = mem[addr_q + AW'(k)];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= INIT;
         ptr           <= '0;
         cnt           <= '0;
         addr_q        <= '0;
         mask_q        <= '0;
         wdata_q       <= '0;
         resp_valid    <= 1'b0;
         resp_is_store <= 1'b0;
         resp_rdata    <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT) ptr <= ptr + AW'(1);
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            mask_q  <= req_mask;
            wdata_q <= req_wdata;
            cnt     <= 3'(RD_LAT-1);
         end
         if (state == RD && cnt != 3'd0) cnt <= cnt - 3'd1;
         if (state == RD && cnt == 3'd0) begin
            resp_valid    <= 1'b1;
            resp_is_store <= 1'b0;
            resp_rdata    <= rd_data;
         end
         if (state == WR) begin
            resp_valid    <= 1'b1;
            resp_is_store <= 1'b1;
            resp_rdata    <= '0;
         end
         if (state == RESP && resp_ready) resp_valid <= 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (state == INIT) mem[ptr] <= VSEW'(ptr) + VSEW'(1);
      if (state == WR)
         for (int k = 0; k < LANES; k++)
            if (mask_q[k]) mem[addr_q + AW'(k)] <= wdata_q[k*VSEW +: VSEW];
   end
endmodule
